// File: rtl/mem_copy_master.sv
// ---------------------------------------------------------------------------
// mem_copy_master
//
// Purpose:
//   Bus master that copies `len` bytes from src_addr to dst_addr, one byte at
//   a time, through a single shared address/data bus.
//
//   Each byte takes three cycles:
//     RD  : present the source address with we=0.
//     CAP : capture the read data.
//     WR  : present the destination address and data with we=1.
//
//   If the decoder deasserts cs for an address that this block drives, the
//   transfer aborts, err is raised and done still pulses.
//
// Handshake:
//   start is a level sampled only in IDLE. An accepted start loads the
//   arguments, clears err and begins the copy. busy is high while a copy is
//   running. done pulses for one cycle when the copy ends, whether it ended
//   normally or aborted. A new start is taken only after done.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   start          copy request (ignored unless IDLE)
//   src_addr       first source byte address
//   dst_addr       first destination byte address
//   len            number of bytes to copy (0 allowed)
//   busy           copy in progress
//   done           one-cycle end-of-transfer pulse
//   err            last transfer aborted on an unselected access
//   we             bus write enable
//   addr           bus address
//   din            bus write data
//   dout           bus read data, valid the cycle after addr with we=0
//   cs             decoder select for the current addr
//   fsm_state      current FSM state (IDLE=0, RD=1, CAP=2, WR=3, FIN=4)
// ---------------------------------------------------------------------------
module mem_copy_master #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [7:0]        len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] din,
   input  logic [DATA_W-1:0] dout,
   input  logic              cs,
   output logic [2:0]        fsm_state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [7:0]        remaining;

   assign fsm_state = state;

   // All bus outputs are registered. Each output is loaded on the edge that
   // enters the state that needs it. din serves as the byte data register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         we        <= 1'b0;
         addr      <= '0;
         din       <= '0;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_ptr   <= src_addr;
                  dst_ptr   <= dst_addr;
                  remaining <= len;
                  err       <= 1'b0;
                  if (len == 8'd0) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     busy  <= 1'b1;
                     addr  <= src_addr;
                     we    <= 1'b0;
                     state <= RD;
                  end
               end
            end

            RD: begin
               if (!cs) begin
                  // Unmapped source: stop with addr held, and drive no
                  // further access.
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  state <= CAP;
               end
            end

            CAP: begin
               din   <= dout;
               addr  <= dst_ptr;
               we    <= 1'b1;
               state <= WR;
            end

            WR: begin
               we <= 1'b0;
               if (!cs) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  // Pointers wrap naturally at 2^ADDR_W.
                  src_ptr   <= src_ptr + 1'b1;
                  dst_ptr   <= dst_ptr + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining > 8'd1) begin
                     addr  <= src_ptr + 1'b1;
                     state <= RD;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= FIN;
                  end
               end
            end

            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               we    <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_master.sv
// ---------------------------------------------------------------------------
// tb_mem_copy_master
//
// Testbench for mem_copy_master. A memory model answers in 0x0400-0x07FF with
// one-cycle read latency. A reference model replays each copy byte by byte on
// a shadow array and predicts the following:
//   - the number of cycles until done
//   - the number of write strobes
//   - err
//   - the final memory contents
// ---------------------------------------------------------------------------
module tb_mem_copy_master;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] src_addr;
   logic [15:0] dst_addr;
   logic [7:0]  len;
   logic        busy;
   logic        done;
   logic        err;
   logic        we;
   logic [15:0] addr;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        cs;
   logic [2:0]  fsm_state;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];
   int we_cnt   = 0;
   int done_cnt = 0;

   mem_copy_master #(.ADDR_W(16), .DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .we        (we),
      .addr      (addr),
      .din       (din),
      .dout      (dout),
      .cs        (cs),
      .fsm_state (fsm_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   function automatic bit mapped(input logic [15:0] a);
      return (a >= 16'h0400) && (a <= 16'h07FF);
   endfunction

   assign cs = mapped(addr);

   always @(posedge clk) begin
      dout <= mem[addr];
      if (we && cs) mem[addr] <= din;
      if (we)   we_cnt   = we_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
   end

   // ---------------- helpers ----------------
   function automatic int mem_diffs();
      int n = 0;
      for (int a = 0; a < 4096; a++)
         if (mem[a] !== ref_mem[a]) n++;
      return n;
   endfunction

   task automatic preload(input logic [15:0] a, input logic [7:0] v);
      mem[a]     = v;
      ref_mem[a] = v;
   endtask

   // Run one copy and check it against the reference model. When poke is
   // set, start is asserted again with junk arguments while the copy runs.
   task automatic run_copy(input string name, input logic [15:0] s,
                           input logic [15:0] d, input logic [7:0] n,
                           input bit poke);
      int          exp_cyc;
      int          exp_we;
      bit          exp_err;
      int          we0;
      int          done0;
      int          seen;
      int          k;
      int          diffs;
      logic [15:0] sa;
      logic [15:0] da;

      // Reference model: ascending byte copy that stops at the first unmapped
      // access.
      exp_err = 1'b0;
      exp_we  = 0;
      exp_cyc = 3 * int'(n);
      for (int i = 0; i < int'(n); i++) begin
         sa = s + 16'(i);
         da = d + 16'(i);
         if (!mapped(sa)) begin
            exp_err = 1'b1;
            exp_cyc = 3 * i + 1;
            break;
         end
         exp_we++;
         if (!mapped(da)) begin
            exp_err = 1'b1;
            exp_cyc = 3 * i + 3;
            break;
         end
         ref_mem[da] = ref_mem[sa];
      end

      @(negedge clk);
      start    = 1'b1;
      src_addr = s;
      dst_addr = d;
      len      = n;
      we0      = we_cnt;
      done0    = done_cnt;
      @(posedge clk);
      #1;
      start    = 1'b0;
      src_addr = 16'($urandom);
      dst_addr = 16'($urandom);
      len      = 8'($urandom);

      total++;
      if (busy !== (n != 0)) begin
         bad++;
         $display("FAIL %s busy_after_start: got %b want %b", name, busy, (n != 0));
      end

      seen = -1;
      k    = 0;
      while (k <= 200) begin
         if (done === 1'b1) begin
            seen = k;
            break;
         end
         start = (poke && k >= 4 && k <= 6);
         @(posedge clk);
         #1;
         k++;
      end
      start = 1'b0;

      total++;
      if (seen != exp_cyc) begin
         bad++;
         $display("FAIL %s done_latency: got %0d want %0d", name, seen, exp_cyc);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy_at_done: got %b want 0", name, busy);
      end
      total++;
      if (err !== exp_err) begin
         bad++;
         $display("FAIL %s err: got %b want %b", name, err, exp_err);
      end

      repeat (4) @(posedge clk);
      #1;
      total++;
      if (done_cnt - done0 != 1) begin
         bad++;
         $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - done0);
      end
      total++;
      if (we_cnt - we0 != exp_we) begin
         bad++;
         $display("FAIL %s write_strobes: got %0d want %0d", name, we_cnt - we0, exp_we);
      end
      total++;
      diffs = mem_diffs();
      if (diffs != 0) begin
         bad++;
         $display("FAIL %s memory: got %0d differing bytes want 0", name, diffs);
      end
      total++;
      if (err !== exp_err) begin
         bad++;
         $display("FAIL %s err_held: got %b want %b", name, err, exp_err);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst      = 1'b1;
      start    = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len      = '0;
      for (int a = 0; a < 65536; a++) preload(16'(a), 8'($urandom));
      #1;
      total++;
      if ({busy, done, err, we, addr, din} !== 20'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %0h want 0", {busy, done, err, we, addr, din});
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic_copy();
      preload(16'h0400, 8'hAA);
      preload(16'h0401, 8'hBB);
      preload(16'h0402, 8'hCC);
      run_copy("basic3", 16'h0400, 16'h0500, 8'd3, 1'b0);
      total++;
      if ({mem[16'h0500], mem[16'h0501], mem[16'h0502]} !== 24'hAABBCC) begin
         bad++;
         $display("FAIL basic3_bytes: got %0h want aabbcc",
                  {mem[16'h0500], mem[16'h0501], mem[16'h0502]});
      end
   endtask

   task automatic test_dst_unmapped();
      run_copy("dst_unmapped", 16'h0400, 16'h0200, 8'd2, 1'b0);
   endtask

   task automatic test_zero_len();
      run_copy("zero_len", 16'h0410, 16'h0510, 8'd0, 1'b0);
   endtask

   task automatic test_start_while_busy();
      run_copy("busy_restart", 16'h0420, 16'h0530, 8'd4, 1'b1);
   endtask

   task automatic test_src_boundary();
      run_copy("src_boundary", 16'h07FE, 16'h0600, 8'd3, 1'b0);
   endtask

   task automatic test_reset_mid();
      int we0;
      int done0;
      int diffs;
      // Only the first byte completes before the reset.
      ref_mem[16'h0540] = ref_mem[16'h0440];
      @(negedge clk);
      start    = 1'b1;
      src_addr = 16'h0440;
      dst_addr = 16'h0540;
      len      = 8'd4;
      we0      = we_cnt;
      done0    = done_cnt;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
      end
      total++;
      if (we !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_second_wr: got we=%b want 1", we);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({busy, done, err, we, addr, din} !== 20'd0) begin
         bad++;
         $display("FAIL rst_mid_outputs: got %0h want 0", {busy, done, err, we, addr, din});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (done_cnt != done0 || we_cnt - we0 != 1) begin
         bad++;
         $display("FAIL rst_mid_counts: got done=%0d we=%0d want done=0 we=1",
                  done_cnt - done0, we_cnt - we0);
      end
      total++;
      diffs = mem_diffs();
      if (diffs != 0) begin
         bad++;
         $display("FAIL rst_mid_memory: got %0d differing bytes want 0", diffs);
      end
   endtask

   task automatic test_after_reset();
      run_copy("after_reset", 16'h0450, 16'h0550, 8'd2, 1'b0);
   endtask

   task automatic test_random();
      logic [15:0] s;
      logic [15:0] d;
      logic [7:0]  n;
      for (int i = 0; i < 10; i++) begin
         s = 16'($urandom_range(16'h03F8, 16'h07FF));
         d = 16'($urandom_range(16'h03F8, 16'h0808));
         n = 8'($urandom_range(0, 12));
         run_copy($sformatf("rand%0d", i), s, d, n, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_back_to_back();
      run_copy("b2b_a", 16'h0460, 16'h0461, 8'd5, 1'b0);
      run_copy("b2b_b", 16'h0470, 16'h0600, 8'd1, 1'b0);
   endtask

   // ---------------- sequence ----------------
   initial begin
      test_reset();
      test_basic_copy();
      test_dst_unmapped();
      test_zero_len();
      test_start_while_busy();
      test_src_boundary();
      test_reset_mid();
      test_after_reset();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_copy_master.md
MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 Parameter: ADDR_W, 16, bus address width.
REQ-002 Parameter: DATA_W, 8, bus data width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-006 Port: src_addr  input  ADDR_W  first source byte address; captured at accepted start.
REQ-007 Port: dst_addr  input  ADDR_W  first destination byte address; captured at accepted start.
REQ-008 Port: len  input  8  byte count; captured at accepted start.
REQ-009 Port: busy  output  1  high from the cycle after accepted start until done.
REQ-010 Port: done  output  1  one-cycle pulse at transfer end (normal or aborted).
REQ-011 Port: err  output  1  high when the last transfer aborted on an unselected access; held until the next accepted start.
REQ-012 Port: we  output  1  bus write enable to the decoded memory system.
REQ-013 Port: addr  output  ADDR_W  bus address.
REQ-014 Port: din  output  DATA_W  bus write data.
REQ-015 Port: dout  input  DATA_W  bus read data; valid the cycle after addr is presented with we=0.
REQ-016 Port: cs  input  1  decoder chip select for the current addr; low means out of the mapped range.

Function
REQ-017 The block SHALL use FSM states IDLE, RD, CAP, WR, FIN.
REQ-018 IDLE: start=1 SHALL capture src_addr, dst_addr and len, clear err, and go to RD, or to FIN if len=0.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 RD: addr=src pointer and we=0 SHALL be driven; cs=0 SHALL set err and go to FIN; otherwise go to CAP.
REQ-021 CAP: dout SHALL be latched into the data register, with addr held at the src pointer and we=0; go to WR.
REQ-022 WR: addr=dst pointer, din=data register and we=1 SHALL be driven for exactly one cycle.
REQ-023 WR with cs=0: err SHALL be set and the FSM SHALL go to FIN.
REQ-024 WR with cs=1: both pointers SHALL increment and remaining SHALL decrement; go to RD if the remaining count before decrement was greater than 1, else go to FIN.
REQ-025 Each byte SHALL take exactly 3 cycles (RD, CAP, WR); N bytes SHALL take 3N cycles from accepted start to FIN.
REQ-026 FIN: done=1 for one cycle, then return to IDLE; busy SHALL be low in FIN and IDLE.
REQ-027 Pointers SHALL wrap modulo 2^ADDR_W (0xFFFF+1 = 0x0000) with no error.
REQ-028 we SHALL be 0 in every state other than WR.
REQ-029 Outside WR, din SHALL hold its last value.
REQ-030 In IDLE and FIN, addr SHALL hold its last value.
REQ-031 On abort, no further bus access SHALL occur.
REQ-032 Overlapping src/dst ranges SHALL be copied in ascending order with no hazard handling.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, with busy=0, done=0, err=0, we=0, addr=0, din=0, pointers=0 and remaining=0.
REQ-034 rst asserted mid-transfer SHALL abort with no done pulse and no further write.
REQ-035 After rst is released, the first rising edge with start=1 SHALL be accepted.

Verification
Bench memory model: valid window 0x0400-0x07FF (cs=1), read data valid the cycle after addr.
REQ-036 Preload 0x0400=AA, 0x0401=BB, 0x0402=CC; start with src=0x0400, dst=0x0500, len=3 -> 0x0500..0x0502 = AA,BB,CC; done 9 cycles after start; err=0.
REQ-037 Start with src=0x0400, dst=0x0200, len=2 -> err=1, done pulse, no write to any address, memory unchanged.
REQ-038 Start with len=0 -> done on the cycle after start, we never asserted, err=0.
REQ-039 Assert start again while busy during an active len=4 copy -> ignored; exactly 4 writes; single done pulse.
REQ-040 Start with src=0x07FE, dst=0x0600, len=3 -> two bytes copied, third read at 0x0800 aborts with err=1.
REQ-041 Assert rst during the second WR of a len=4 copy -> we=0 immediately, busy=0, no done pulse, only the first byte written.
